// File: rtl/instruction_fetch.sv
// Fetch stage for the 8-bit core.
// Owns the program counter, drives the ROM address, and assembles 1- or 2-byte
// instructions. Each instruction is handed to execute through a valid/ready pair.
// A branch redirect from execute flushes any partially fetched or held instruction.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// FETCH0 | sample opcode byte at pc, decode instruction length
// FETCH1 | sample second byte (immediate / branch target) of a 2-byte instr
// HOLD   | complete instruction presented, waiting for instr_ready
module instruction_fetch #(
  parameter logic [7:0] RESET_PC = 8'd0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] address_bus,
  input  logic [7:0] data_bus,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_byte0,
  output logic [7:0] instr_byte1,
  output logic       instr_two_byte,
  output logic [7:0] instr_addr,
  input  logic       branch_taken,
  input  logic [7:0] branch_target
);

  typedef enum logic [1:0] {
    FETCH0 = 2'd0,
    FETCH1 = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] pc, pc_nxt;
  logic [7:0] byte0_nxt, byte1_nxt, addr_nxt;
  logic       valid_nxt, two_byte_nxt;
  logic       two_byte;

  // The ROM address comes straight from the pc register, never from a comb path.
  assign address_bus = pc;

  // LD_IMM/CMP_IMM family (1000xxxx) and branches (101xxxxx) carry a second byte.
  assign two_byte = (data_bus[7:4] == 4'b1000) | (data_bus[7:5] == 3'b101);

  // State and output registers; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= FETCH0;
      pc             <= RESET_PC;
      instr_valid    <= 1'b0;
      instr_byte0    <= 8'd0;
      instr_byte1    <= 8'd0;
      instr_two_byte <= 1'b0;
      instr_addr     <= RESET_PC;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      instr_valid    <= valid_nxt;
      instr_byte0    <= byte0_nxt;
      instr_byte1    <= byte1_nxt;
      instr_two_byte <= two_byte_nxt;
      instr_addr     <= addr_nxt;
    end
  end

  // Next-state and next-output logic; a redirect overrides the normal transition.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    valid_nxt    = instr_valid;
    byte0_nxt    = instr_byte0;
    byte1_nxt    = instr_byte1;
    two_byte_nxt = instr_two_byte;
    addr_nxt     = instr_addr;

    case (state)
      FETCH0: begin
        byte0_nxt    = data_bus;
        addr_nxt     = pc;
        pc_nxt       = pc + 8'd1;
        two_byte_nxt = two_byte;
        if (two_byte) begin
          state_nxt = FETCH1;
        end else begin
          byte1_nxt = 8'd0;
          valid_nxt = 1'b1;
          state_nxt = HOLD;
        end
      end
      FETCH1: begin
        byte1_nxt = data_bus;
        pc_nxt    = pc + 8'd1;
        valid_nxt = 1'b1;
        state_nxt = HOLD;
      end
      HOLD: begin
        // pc already points past the held instruction, so it is left alone.
        if (instr_ready) begin
          valid_nxt = 1'b0;
          state_nxt = FETCH0;
        end
      end
      default: begin
        valid_nxt = 1'b0;
        state_nxt = FETCH0;
      end
    endcase

    // Byte registers may keep stale contents; only valid is cleared.
    if (branch_taken) begin
      pc_nxt    = branch_target;
      valid_nxt = 1'b0;
      state_nxt = FETCH0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed sequences, an opcode
// length table, and a randomized run against a transaction-level model.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] address_bus;
  logic [7:0] data_bus;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_byte0;
  logic [7:0] instr_byte1;
  logic       instr_two_byte;
  logic [7:0] instr_addr;
  logic       branch_taken;
  logic [7:0] branch_target;

  logic [7:0] rom [256];
  int n_cmp = 0;
  int n_bad = 0;

  instruction_fetch #(.RESET_PC(8'd0)) dut (
    .clk            (clk),
    .reset          (reset),
    .address_bus    (address_bus),
    .data_bus       (data_bus),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_byte0    (instr_byte0),
    .instr_byte1    (instr_byte1),
    .instr_two_byte (instr_two_byte),
    .instr_addr     (instr_addr),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target)
  );

  assign data_bus = rom[address_bus];

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Steps until instr_valid is seen or the budget runs out (counted as a failure).
  task automatic wait_valid(input string name, input int max_cycles);
    int k;
    k = 0;
    while (!instr_valid && k < max_cycles) begin
      step();
      k++;
    end
    n_cmp++;
    if (!instr_valid) begin
      n_bad++;
      $display("FAIL %s: instr_valid got 0 expected 1 within %0d cycles", name, max_cycles);
    end
  endtask

  // Instruction length from the opcode value ranges.
  function automatic int instr_len(input logic [7:0] b);
    if ((b >= 8'h80 && b <= 8'h8F) || (b >= 8'hA0 && b <= 8'hBF)) return 2;
    return 1;
  endfunction

  typedef struct {
    logic [7:0] op;
    logic       exp_two;
    logic [7:0] exp_b1;
    logic [7:0] exp_next;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int k;
    bit saw7;
    logic [7:0] m_start;
    int m_since, m_len, m_min;
    bit m_valid;
    bit r_ready, r_br;
    logic [7:0] r_tgt;

    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    rom[0]  = 8'h81; rom[1]  = 8'h00; rom[2]  = 8'h10; rom[3]  = 8'h20;
    rom[4]  = 8'h98; rom[5]  = 8'h01; rom[6]  = 8'h02; rom[7]  = 8'h8D;
    rom[8]  = 8'h33; rom[9]  = 8'h11; rom[10] = 8'h12; rom[11] = 8'hA8;
    rom[12] = 8'h04; rom[26] = 8'h44; rom[255] = 8'hA8;

    reset = 1'b1; instr_ready = 1'b0; branch_taken = 1'b0; branch_target = 8'd0;

    // Reset held two cycles
    step();
    chk("reset_addr", address_bus, 8'd0);
    chk("reset_valid", instr_valid, 1'b0);
    step();
    chk("reset_addr2", address_bus, 8'd0);
    chk("reset_valid2", instr_valid, 1'b0);
    chk("reset_byte0", instr_byte0, 8'd0);
    chk("reset_byte1", instr_byte1, 8'd0);
    chk("reset_two", instr_two_byte, 1'b0);
    chk("reset_iaddr", instr_addr, 8'd0);

    // 2-byte fetch LD_IMM at 0
    reset = 1'b0; instr_ready = 1'b1;
    step();
    chk("ld_f1_valid", instr_valid, 1'b0);
    chk("ld_f1_addr", address_bus, 8'd1);
    step();
    chk("ld_valid", instr_valid, 1'b1);
    chk("ld_byte0", instr_byte0, 8'h81);
    chk("ld_byte1", instr_byte1, 8'h00);
    chk("ld_two", instr_two_byte, 1'b1);
    chk("ld_iaddr", instr_addr, 8'd0);
    chk("ld_addr_after", address_bus, 8'd2);

    // Advance to INPUT at 4, then stall five cycles
    k = 0;
    while (!(instr_valid && instr_addr == 8'd4) && k < 12) begin step(); k++; end
    chk("in_reached", {instr_valid, instr_addr}, {1'b1, 8'd4});
    instr_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_valid", instr_valid, 1'b1);
      chk("stall_byte0", instr_byte0, 8'h98);
      chk("stall_byte1", instr_byte1, 8'h00);
      chk("stall_two", instr_two_byte, 1'b0);
      chk("stall_iaddr", instr_addr, 8'd4);
      chk("stall_addr", address_bus, 8'd5);
    end
    instr_ready = 1'b1;
    step();
    chk("release_valid", instr_valid, 1'b0);
    chk("release_addr", address_bus, 8'd5);
    step();
    chk("next_iaddr", {instr_valid, instr_addr}, {1'b1, 8'd5});

    // Redirect while in FETCH1 of CMP_IMM at 7
    saw7 = 1'b0;
    k = 0;
    while (!(address_bus == 8'd8 && !instr_valid) && k < 12) begin step(); k++; end
    chk("cmp_in_fetch1", {instr_valid, address_bus}, {1'b0, 8'd8});
    branch_taken = 1'b1; branch_target = 8'd26;
    step();
    branch_taken = 1'b0;
    chk("mid_redir_addr", address_bus, 8'd26);
    chk("mid_redir_valid", instr_valid, 1'b0);
    k = 0;
    while (!instr_valid && k < 4) begin step(); k++; end
    if (instr_valid && instr_addr == 8'd7) saw7 = 1'b1;
    chk("mid_redir_iaddr", {instr_valid, instr_addr}, {1'b1, 8'd26});
    chk("no_valid_from_7", saw7, 1'b0);

    // Redirect at HOLD of BRA at 11, together with instr_ready
    branch_taken = 1'b1; branch_target = 8'd11;
    step();
    branch_taken = 1'b0;
    wait_valid("bra_valid", 4);
    chk("bra_fields", {instr_byte0, instr_byte1, instr_addr, 7'd0, instr_two_byte},
        {8'hA8, 8'h04, 8'd11, 7'd0, 1'b1});
    branch_taken = 1'b1; branch_target = 8'd4; instr_ready = 1'b1;
    step();
    branch_taken = 1'b0;
    chk("bra_redir_addr", address_bus, 8'd4);
    chk("bra_redir_valid", instr_valid, 1'b0);
    wait_valid("bra_follow_valid", 4);
    chk("bra_follow_iaddr", instr_addr, 8'd4);

    // PC wrap from 255
    rom[0] = 8'h1A;
    branch_taken = 1'b1; branch_target = 8'd255;
    step();
    branch_taken = 1'b0;
    wait_valid("wrap_valid", 4);
    chk("wrap_byte0", instr_byte0, 8'hA8);
    chk("wrap_byte1", instr_byte1, 8'h1A);
    chk("wrap_iaddr", instr_addr, 8'd255);
    chk("wrap_addr", address_bus, 8'd1);

    // Reset while in FETCH1
    branch_taken = 1'b1; branch_target = 8'd11;
    step();
    branch_taken = 1'b0;
    step();
    chk("pre_reset_fetch1", {instr_valid, address_bus}, {1'b0, 8'd12});
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midreset_valid", instr_valid, 1'b0);
    chk("midreset_addr", address_bus, 8'd0);

    // Length-decode table: opcode at 100, second byte 0x5A at 101
    vecs[0]  = '{8'h80, 1'b1, 8'h5A, 8'd102};
    vecs[1]  = '{8'h8F, 1'b1, 8'h5A, 8'd102};
    vecs[2]  = '{8'h84, 1'b1, 8'h5A, 8'd102};
    vecs[3]  = '{8'h88, 1'b1, 8'h5A, 8'd102};
    vecs[4]  = '{8'hA0, 1'b1, 8'h5A, 8'd102};
    vecs[5]  = '{8'hBF, 1'b1, 8'h5A, 8'd102};
    vecs[6]  = '{8'h7F, 1'b0, 8'h00, 8'd101};
    vecs[7]  = '{8'h90, 1'b0, 8'h00, 8'd101};
    vecs[8]  = '{8'h9F, 1'b0, 8'h00, 8'd101};
    vecs[9]  = '{8'hC0, 1'b0, 8'h00, 8'd101};
    vecs[10] = '{8'h00, 1'b0, 8'h00, 8'd101};
    vecs[11] = '{8'hFF, 1'b0, 8'h00, 8'd101};
    vecs[12] = '{8'h40, 1'b0, 8'h00, 8'd101};
    vecs[13] = '{8'hE5, 1'b0, 8'h00, 8'd101};
    rom[101] = 8'h5A;
    instr_ready = 1'b0;
    for (int v = 0; v < 14; v++) begin
      rom[100] = vecs[v].op;
      branch_taken = 1'b1; branch_target = 8'd100;
      step();
      branch_taken = 1'b0;
      chk("tbl_start_valid", instr_valid, 1'b0);
      wait_valid("tbl_valid", 3);
      chk("tbl_two", instr_two_byte, vecs[v].exp_two);
      chk("tbl_byte0", instr_byte0, vecs[v].op);
      chk("tbl_byte1", instr_byte1, vecs[v].exp_b1);
      chk("tbl_iaddr", instr_addr, 8'd100);
      chk("tbl_next", address_bus, vecs[v].exp_next);
    end

    // Randomized run against a transaction-level model
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    reset = 1'b1; branch_taken = 1'b0; instr_ready = 1'b0;
    step();
    reset = 1'b0;
    m_start = 8'd0;
    m_since = 0;
    for (int c = 0; c < 3000; c++) begin
      r_ready = ($urandom_range(0, 9) < 6);
      r_br    = ($urandom_range(0, 19) == 0);
      r_tgt   = 8'($urandom);
      if (c % 500 == 250) r_tgt = 8'd255;
      instr_ready = r_ready; branch_taken = r_br; branch_target = r_tgt;

      m_len   = instr_len(rom[m_start]);
      m_valid = (m_since >= m_len);
      if (r_br) begin
        m_start = r_tgt; m_since = 0;
      end else if (m_valid && r_ready) begin
        m_start = 8'(m_start + m_len); m_since = 0;
      end else begin
        m_since = (m_since + 1 > m_len) ? m_len : m_since + 1;
      end
      step();

      m_len   = instr_len(rom[m_start]);
      m_valid = (m_since >= m_len);
      m_min   = (m_since < m_len) ? m_since : m_len;
      chk("rnd_valid", instr_valid, m_valid);
      chk("rnd_addr", address_bus, 8'(m_start + m_min));
      if (m_valid) begin
        chk("rnd_iaddr", instr_addr, m_start);
        chk("rnd_byte0", instr_byte0, rom[m_start]);
        chk("rnd_byte1", instr_byte1, (m_len == 2) ? rom[8'(m_start + 1)] : 8'd0);
        chk("rnd_two", instr_two_byte, (m_len == 2));
      end
    end
    branch_taken = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage between program_memory and the execute/decode unit of the 8-bit core. It owns the program counter and drives address_bus into the ROM. It samples the combinational data_bus, assembles 1- or 2-byte instructions and presents them to execute through a valid/ready handshake. It also accepts branch redirects from execute, which flush any partially fetched or held instruction.

Parameters:
RESET_PC, 8'd0, PC value loaded on reset.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
address_bus  output  8  ROM address; always equals the internal pc register.
data_bus  input  8  ROM read data; combinational, same cycle as address_bus.
instr_valid  output  1  a complete instruction is held on instr_byte0/1.
instr_ready  input  1  execute consumes the held instruction this cycle.
instr_byte0  output  8  first instruction byte (opcode and registers).
instr_byte1  output  8  second byte (immediate or branch target); 8'd0 for 1-byte instructions.
instr_two_byte  output  1  held instruction is 2 bytes long.
instr_addr  output  8  ROM address of instr_byte0.
branch_taken  input  1  redirect request from execute.
branch_target  input  8  new PC when branch_taken=1.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: pc=RESET_PC, state=FETCH0, instr_valid=0, instr_byte0=0, instr_byte1=0, instr_two_byte=0, instr_addr=RESET_PC.
- Reset asserted mid-fetch or while holding discards all state and has priority over every other input.
- Length decode, combinational on data_bus in FETCH0:
  - two_byte = (data_bus[7:4]==4'b1000) | (data_bus[7:5]==3'b101).
  - Covers LD_IMM and CMP_IMM (1000xx), plus BRA, BHI and BEQ (101xxxxx). The unused 100001 and 100010 also count as 2-byte.
  - All other encodings are 1-byte: ADD, MUL, MOV, DIV, LDR, STR, INC, DEC, INPUT, OUTPUT, NOP, unknown.
- States: FETCH0, FETCH1, HOLD.
  - FETCH0:
    - instr_byte0<=data_bus, instr_addr<=pc, pc<=pc+1, instr_two_byte<=two_byte.
    - If two_byte, go to FETCH1.
    - Otherwise instr_byte1<=0, instr_valid<=1, go to HOLD.
  - FETCH1: instr_byte1<=data_bus, pc<=pc+1, instr_valid<=1, go to HOLD.
  - HOLD:
    - Outputs stable while instr_ready=0.
    - When instr_ready=1: instr_valid<=0, go to FETCH0. pc is unchanged because it already points at the next instruction.
- Latency and throughput:
  - A 1-byte instruction is valid 1 cycle after entering FETCH0.
  - A 2-byte instruction is valid after 2 cycles.
  - With instr_ready tied high, throughput is one instruction per 2 cycles (1-byte) or per 3 cycles (2-byte).
- instr_valid must never be 1 outside HOLD.
- Redirect (branch_taken=1), any state:
  - pc<=branch_target, instr_valid<=0, go to FETCH0.
  - Any partial byte0 is discarded; output byte registers may keep stale values while invalid.
- Redirect in HOLD in the same cycle as instr_ready=1: the held instruction counts as consumed and the redirect is taken. Same result as a redirect alone.
- Redirect takes precedence over the normal FETCH0/FETCH1 transition in the same cycle.
- PC arithmetic is 8-bit modulo:
  - 8'd255+1 = 8'd0, no error flag.
  - A 2-byte instruction at address 255 takes byte1 from address 0, and the next fetch is at address 1.
- address_bus is driven only from the pc register: no combinational path from branch_target or data_bus.

Test Plan:
- Reset: hold reset=1 for 2 cycles with RESET_PC=0, then release.
  - address_bus=0, instr_valid=0 during reset.
  - The first posedge after release samples rom[0].
- 2-byte fetch: rom[0]=0x81, rom[1]=0x00 (LD_IMM R1,#0), instr_ready=1.
  - instr_valid=1 two cycles after release, with byte0=0x81, byte1=0x00, two_byte=1, instr_addr=0.
  - address_bus=2 afterwards.
- 1-byte fetch and stall: rom[4]=0x98 (INPUT R0), instr_ready=0 for 5 cycles.
  - instr_valid stays 1; byte0=0x98, byte1=0, two_byte=0, instr_addr=4 stable; address_bus=5 throughout.
  - Raising instr_ready causes the next fetch at address 5.
- Branch redirect: at the HOLD of BRA 0x04 (0xA8, 0x04) at address 11, assert branch_taken=1, branch_target=8'd4 together with instr_ready.
  - Next cycle address_bus=4, instr_valid=0.
  - Following instruction has instr_addr=4.
- Redirect mid-fetch: assert branch_taken with target 8'd26 while in FETCH1 of CMP_IMM (0x8D) at address 7.
  - No instruction from address 7 is ever marked valid; the next valid instruction has instr_addr=26.
- Wrap and reset mid-operation:
  - pc=255 with rom[255]=0xA8, rom[0]=0x1A gives byte0=0xA8, byte1=0x1A, instr_addr=255; address_bus then equals 1.
  - Asserting reset in FETCH1 gives instr_valid=0 and address_bus=RESET_PC on the next cycle.
